// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Purpose:
//   Sequences the shared multiply and divide units of the multicycle CPU.
//   One request at a time is accepted from the main control FSM. The block
//   fires a one-cycle start pulse at the selected unit, then waits for that
//   unit's stop flag. On completion it steers the Hi/Lo source muxes, loads
//   Hi/Lo and pulses done. A zero divisor or watchdog expiry aborts the
//   operation and raises a one-cycle exception pulse instead.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum cycles spent in WAIT before a timeout abort (>= 2)
//   CNT_W           watchdog counter width (2**CNT_W > TIMEOUT_CYCLES)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-low reset (0 = reset)
//   req           in   start request, sampled only in IDLE
//   op            in   operation select latched with req: 0 = mult, 1 = div
//   mult_stop     in   multiplier finished
//   div_stop      in   divider finished
//   div_zero      in   divider reports a zero divisor
//   mult_control  out  one-cycle multiplier start pulse
//   div_control   out  one-cycle divider start pulse
//   sel_mux_hi    out  Hi source select: 0 = div, 1 = mult
//   sel_mux_lo    out  Lo source select: 0 = div, 1 = mult
//   HiLo_load     out  Hi/Lo register write enable
//   busy          out  high in every state except IDLE
//   done          out  one-cycle completion pulse, Hi/Lo already valid
//   div_zero_exc  out  one-cycle divide-by-zero exception pulse
//   timeout_exc   out  one-cycle watchdog exception pulse
//
// All outputs are registered: they are decoded from the next state and
// stored on the same edge as the state, so each output is a pure function
// of the state the FSM is in during that cycle (Moore behaviour without
// combinational output paths).
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic op,
  input  logic mult_stop,
  input  logic div_stop,
  input  logic div_zero,
  output logic mult_control,
  output logic div_control,
  output logic sel_mux_hi,
  output logic sel_mux_lo,
  output logic HiLo_load,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout_exc
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  // Last counter value allowed in WAIT; reaching it without a stop aborts.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Registered FSM state and per-operation context.
  state_t           state_r;
  logic             op_r;        // latched operation: 0 = mult, 1 = div
  logic             cause_dz_r;  // abort cause: 1 = div_zero, 0 = timeout
  logic [CNT_W-1:0] cnt_r;       // watchdog counter, runs only in WAIT

  // Next-state values.
  state_t           state_nxt_s;
  logic             op_nxt_s;
  logic             cause_dz_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next values of the registered outputs.
  logic mult_control_nxt_s;
  logic div_control_nxt_s;
  logic sel_nxt_s;
  logic hilo_load_nxt_s;
  logic busy_nxt_s;
  logic done_nxt_s;
  logic div_zero_exc_nxt_s;
  logic timeout_exc_nxt_s;

  // Stop flag of the unit chosen by the latched op; the other unit is ignored.
  logic stop_sel_s;
  assign stop_sel_s = op_r ? div_stop : mult_stop;

  // Next-state logic: transitions, op latch, abort cause and watchdog.
  always_comb begin
    state_nxt_s    = state_r;
    op_nxt_s       = op_r;
    cause_dz_nxt_s = cause_dz_r;
    cnt_nxt_s      = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_nxt_s = ST_START;
          op_nxt_s    = op;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_nxt_s   = CNT_ZERO;
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_nxt_s = cnt_r + CNT_ONE;
        // Priority: zero divisor, then the selected stop, then the watchdog.
        if (op_r && div_zero) begin
          state_nxt_s    = ST_ABORT;
          cause_dz_nxt_s = 1'b1;
        end else if (stop_sel_s) begin
          state_nxt_s = ST_WRITE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s    = ST_ABORT;
          cause_dz_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WRITE: begin
        state_nxt_s = ST_FIN;
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      ST_ABORT: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        // Unreachable encodings recover to a clean IDLE.
        state_nxt_s    = ST_IDLE;
        op_nxt_s       = 1'b0;
        cause_dz_nxt_s = 1'b0;
        cnt_nxt_s      = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they belong to.
  always_comb begin
    mult_control_nxt_s = 1'b0;
    div_control_nxt_s  = 1'b0;
    hilo_load_nxt_s    = 1'b0;
    done_nxt_s         = 1'b0;
    div_zero_exc_nxt_s = 1'b0;
    timeout_exc_nxt_s  = 1'b0;
    busy_nxt_s         = 1'b1;
    sel_nxt_s          = sel_mux_hi;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
        sel_nxt_s  = sel_mux_hi;  // hold the last steering in IDLE
      end
      ST_START: begin
        mult_control_nxt_s = ~op_nxt_s;
        div_control_nxt_s  = op_nxt_s;
        sel_nxt_s          = ~op_nxt_s;  // mux encoding: 1 = mult, 0 = div
      end
      ST_WAIT: begin
        sel_nxt_s = ~op_nxt_s;
      end
      ST_WRITE: begin
        hilo_load_nxt_s = 1'b1;
        sel_nxt_s       = ~op_nxt_s;
      end
      ST_FIN: begin
        done_nxt_s = 1'b1;
        sel_nxt_s  = ~op_nxt_s;
      end
      ST_ABORT: begin
        div_zero_exc_nxt_s = cause_dz_nxt_s;
        timeout_exc_nxt_s  = ~cause_dz_nxt_s;
        sel_nxt_s          = ~op_nxt_s;
      end
      default: begin
        busy_nxt_s = 1'b0;
        sel_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, context and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      op_r         <= 1'b0;
      cause_dz_r   <= 1'b0;
      cnt_r        <= CNT_ZERO;
      mult_control <= 1'b0;
      div_control  <= 1'b0;
      sel_mux_hi   <= 1'b0;
      sel_mux_lo   <= 1'b0;
      HiLo_load    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout_exc  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      op_r         <= op_nxt_s;
      cause_dz_r   <= cause_dz_nxt_s;
      cnt_r        <= cnt_nxt_s;
      mult_control <= mult_control_nxt_s;
      div_control  <= div_control_nxt_s;
      sel_mux_hi   <= sel_nxt_s;
      sel_mux_lo   <= sel_nxt_s;
      HiLo_load    <= hilo_load_nxt_s;
      busy         <= busy_nxt_s;
      done         <= done_nxt_s;
      div_zero_exc <= div_zero_exc_nxt_s;
      timeout_exc  <= timeout_exc_nxt_s;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed bench for muldiv_sequencer. Two instances share the stimulus:
// "dut" with the default watchdog (40) and "dut8" with TIMEOUT_CYCLES = 8,
// which has its own req so it only runs the watchdog scenarios.
// Cycle n of a scenario is the clock period after the n-th rising edge of
// that scenario; inputs are driven and outputs sampled 1 time unit after
// the edge. Output vectors are {mult_control, div_control, sel_mux_hi,
// sel_mux_lo, HiLo_load, busy, done, div_zero_exc, timeout_exc}.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset, req, req8, op, mult_stop, div_stop, div_zero;

  logic mult_control, div_control, sel_mux_hi, sel_mux_lo, HiLo_load;
  logic busy, done, div_zero_exc, timeout_exc;
  logic mult_control8, div_control8, sel_mux_hi8, sel_mux_lo8, HiLo_load8;
  logic busy8, done8, div_zero_exc8, timeout_exc8;

  logic [8:0] obs_m, obs_8;

  int checks = 0;
  int errors = 0;

  // 10-unit clock.
  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .op(op),
    .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero),
    .mult_control(mult_control), .div_control(div_control),
    .sel_mux_hi(sel_mux_hi), .sel_mux_lo(sel_mux_lo),
    .HiLo_load(HiLo_load), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .timeout_exc(timeout_exc)
  );

  muldiv_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .op(op),
    .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero),
    .mult_control(mult_control8), .div_control(div_control8),
    .sel_mux_hi(sel_mux_hi8), .sel_mux_lo(sel_mux_lo8),
    .HiLo_load(HiLo_load8), .busy(busy8), .done(done8),
    .div_zero_exc(div_zero_exc8), .timeout_exc(timeout_exc8)
  );

  assign obs_m = {mult_control, div_control, sel_mux_hi, sel_mux_lo, HiLo_load,
                  busy, done, div_zero_exc, timeout_exc};
  assign obs_8 = {mult_control8, div_control8, sel_mux_hi8, sel_mux_lo8, HiLo_load8,
                  busy8, done8, div_zero_exc8, timeout_exc8};

  // Build an expected vector; both select outputs share one expected value.
  function automatic logic [8:0] ev(input logic mc, input logic dc, input logic sel,
                                    input logic ld, input logic bz, input logic dn,
                                    input logic dz, input logic to);
    return {mc, dc, sel, sel, ld, bz, dn, dz, to};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%b expected=%b", tag, c, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; req8 = 1'b0; op = 1'b0;
    mult_stop = 1'b0; div_stop = 1'b0; div_zero = 1'b0;
    tick();
    tick();
    chk("reset_main", 0, obs_m, 9'b0);
    chk("reset_t8", 0, obs_8, 9'b0);
    reset = 1'b1;

    // Multiply: stop at cycle 34 -> load 35, done 36, idle 37.
    for (int c = 0; c <= 37; c++) begin
      req = (c == 0); op = 1'b0; mult_stop = (c == 34);
      chk("mult", c, obs_m,
          ev(c == 1, 1'b0, c >= 1, c == 35, c >= 1 && c <= 36, c == 36, 1'b0, 1'b0));
      tick();
    end
    mult_stop = 1'b0;

    // Divide by zero beats div_stop at cycle 3; sel held at 1 in cycle 0.
    for (int c = 0; c <= 5; c++) begin
      req = (c == 0); op = 1'b1; div_zero = (c == 3); div_stop = (c == 3);
      chk("divzero", c, obs_m,
          ev(1'b0, c == 1, c == 0, 1'b0, c >= 1 && c <= 4, 1'b0, c == 4, 1'b0));
      tick();
    end
    div_zero = 1'b0; div_stop = 1'b0;

    // Watchdog with TIMEOUT_CYCLES=8: WAIT spans 2..9, exception at 10.
    for (int c = 0; c <= 11; c++) begin
      req8 = (c == 0); op = 1'b1;
      chk("timeout", c, obs_8,
          ev(1'b0, c == 1, 1'b0, 1'b0, c >= 1 && c <= 10, 1'b0, 1'b0, c == 10));
      tick();
    end

    // Stop in the last WAIT cycle (cycle 9) beats the watchdog.
    for (int c = 0; c <= 12; c++) begin
      req8 = (c == 0); op = 1'b0; mult_stop = (c == 9);
      chk("stop_vs_wdog", c, obs_8,
          ev(c == 1, 1'b0, c >= 1, c == 10, c >= 1 && c <= 11, c == 11, 1'b0, 1'b0));
      tick();
    end
    mult_stop = 1'b0;

    // Wrong-unit stop and extra requests are ignored during a divide.
    for (int c = 0; c <= 15; c++) begin
      req = (c == 0) || (c >= 2 && c <= 8);
      op = (c == 0);
      mult_stop = (c == 5); div_stop = (c == 12);
      chk("wrong_stop", c, obs_m,
          ev(1'b0, c == 1, 1'b0, c == 13, c >= 1 && c <= 14, c == 14, 1'b0, 1'b0));
      tick();
    end
    mult_stop = 1'b0; div_stop = 1'b0;

    // Reset mid-multiply at cycle 10; late stop at 12 must not load.
    for (int c = 0; c <= 14; c++) begin
      req = (c == 0); op = 1'b0;
      reset = (c == 10) ? 1'b0 : 1'b1;
      mult_stop = (c == 12);
      if (c <= 10) begin
        chk("reset_midop", c, obs_m,
            ev(c == 1, 1'b0, c >= 1, 1'b0, c >= 1, 1'b0, 1'b0, 1'b0));
      end else begin
        chk("reset_midop", c, obs_m, 9'b0);
      end
      if (c == 11) begin
        chk("reset_t8_sel", c, obs_8, 9'b0);
      end
      tick();
    end
    mult_stop = 1'b0;

    // A fresh multiply after reset runs normally.
    for (int c = 0; c <= 7; c++) begin
      req = (c == 0); op = 1'b0; mult_stop = (c == 4);
      chk("after_reset", c, obs_m,
          ev(c == 1, 1'b0, c >= 1, c == 5, c >= 1 && c <= 6, c == 6, 1'b0, 1'b0));
      tick();
    end
    mult_stop = 1'b0;

    // Back-to-back: divide finishes (FIN at 4), req held from 4 -> START at 6.
    for (int c = 0; c <= 12; c++) begin
      req = (c == 0) || (c >= 4 && c <= 8);
      op = (c == 0);
      div_stop = (c == 2); mult_stop = (c == 9);
      chk("back2back", c, obs_m,
          ev(c == 6, c == 1, (c == 0) || (c >= 6), (c == 3) || (c == 10),
             (c >= 1 && c <= 4) || (c >= 6 && c <= 11), (c == 4) || (c == 11),
             1'b0, 1'b0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
